router_sync_gen: RTL and testbench

//  Parametrised synchroniser between the router FSM and NUM_CH output FIFOs.
//  - Latches the destination address from the header byte.
//  - Steers FSM write enables to the addressed FIFO and returns that FIFO's full flag.
//  - Drives per-channel valid outputs.
//  - Issues a per-channel soft reset when a channel is left unread for TIMEOUT cycles.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_sync_gen_if.sv | 50 +++++
 rtl/router_sync_timer.sv | 47 ++++
 rtl/router_sync_gen.sv | 77 +++++++
 tb/tb_router_sync_gen.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared parameters and width helpers for the router output synchroniser.
// The header address field starts at bit 0 of the header byte.
package router_pkg;

    localparam int unsigned NUM_CH_DEF   = 3;
    localparam int unsigned TIMEOUT_DEF  = 30;
    localparam int unsigned HDR_ADDR_LSB = 0;

    // A single-channel router still needs one address bit to flag bad headers.
    function automatic int unsigned addr_w(input int unsigned num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

    localparam int unsigned ADDR_W_DEF = addr_w(NUM_CH_DEF);

endpackage

// File: rtl/router_sync_gen_if.sv
// Handshake bundle between the router FSM / output FIFOs and the synchroniser.
// master = FSM and FIFO side, slave = synchroniser.
interface router_sync_gen_if
    import router_pkg::*;
#(
    parameter  int unsigned NUM_CH = NUM_CH_DEF,
    localparam int unsigned ADDR_W = addr_w(NUM_CH)
) ();

    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic              addr_invalid;

    modport master (
        output detect_add,
        output data_in,
        output write_enb_reg,
        output read_enb,
        output empty,
        output full,
        input  write_enb,
        input  fifo_full,
        input  vld_out,
        input  soft_reset,
        input  addr_invalid
    );

    modport slave (
        input  detect_add,
        input  data_in,
        input  write_enb_reg,
        input  read_enb,
        input  empty,
        input  full,
        output write_enb,
        output fifo_full,
        output vld_out,
        output soft_reset,
        output addr_invalid
    );

endinterface

// File: rtl/router_sync_timer.sv
// One-channel stall timer: pulses soft_reset for one cycle after TIMEOUT
// consecutive edges of valid data that the consumer did not read.
module router_sync_timer
    import router_pkg::*;
#(
    parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
    localparam int unsigned CNT_W   = cnt_w(TIMEOUT)
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        // A read on the terminal edge takes priority over the flush.
        if (!vld || read_enb) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_gen.sv
// Router synchroniser: latches the header address, steers FSM writes to the
// addressed FIFO, reports its full flag and flushes channels left unread.
module router_sync_gen
    import router_pkg::*;
#(
    parameter  int unsigned NUM_CH  = NUM_CH_DEF,
    parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
    localparam int unsigned ADDR_W  = addr_w(NUM_CH)
) (
    input  logic              clock,
    input  logic              resetn,
    router_sync_gen_if.slave  bus
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_invalid;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] soft_reset;

    always_comb begin
        addr_d = addr_q;
        if (bus.detect_add) begin
            addr_d = bus.data_in[HDR_ADDR_LSB +: ADDR_W];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Extra MSB keeps the compare meaningful when NUM_CH is a power of two.
    always_comb begin
        addr_invalid = ({1'b0, addr_q} >= (ADDR_W + 1)'(NUM_CH));
    end

    // Steering uses the registered address, so a header arriving alongside a
    // write still routes that write to the previous channel.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                write_enb[i] = bus.write_enb_reg & ~addr_invalid;
                fifo_full    = bus.full[i] & ~addr_invalid;
            end
        end
    end

    always_comb begin
        vld = ~bus.empty;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (vld[g]),
            .read_enb   (bus.read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

    assign bus.write_enb    = write_enb;
    assign bus.fifo_full    = fifo_full;
    assign bus.vld_out      = vld;
    assign bus.soft_reset   = soft_reset;
    assign bus.addr_invalid = addr_invalid;

endmodule

// File: tb/tb_router_sync_gen.sv
// Directed bench: a 3-channel/30-cycle instance and a 4-channel/8-cycle instance,
// checked against hand-computed values.
module tb_router_sync_gen;

    logic clock;
    logic resetn_a;
    logic resetn_b;
    int   checks;
    int   failures;

    router_sync_gen_if #(.NUM_CH(3)) bus_a ();
    router_sync_gen_if #(.NUM_CH(4)) bus_b ();

    router_sync_gen #(
        .NUM_CH  (3),
        .TIMEOUT (30)
    ) dut_a (
        .clock  (clock),
        .resetn (resetn_a),
        .bus    (bus_a.slave)
    );

    router_sync_gen #(
        .NUM_CH  (4),
        .TIMEOUT (8)
    ) dut_b (
        .clock  (clock),
        .resetn (resetn_b),
        .bus    (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        bus_a.detect_add    = 1'b0;
        bus_a.data_in       = 2'b00;
        bus_a.write_enb_reg = 1'b0;
        bus_a.read_enb      = 3'b000;
        bus_a.empty         = 3'b010;
        bus_a.full          = 3'b001;
        bus_b.detect_add    = 1'b0;
        bus_b.data_in       = 2'b00;
        bus_b.write_enb_reg = 1'b0;
        bus_b.read_enb      = 4'b0000;
        bus_b.empty         = 4'b1111;
        bus_b.full          = 4'b0000;

        // Reset state: address 0, combinational outputs live.
        tick();
        tick();
        chk("rst_write_enb", 8'(bus_a.write_enb), 8'h0);
        chk("rst_soft_reset", 8'(bus_a.soft_reset), 8'h0);
        chk("rst_fifo_full", 8'(bus_a.fifo_full), 8'h1);
        chk("rst_vld_out", 8'(bus_a.vld_out), 8'h5);
        chk("rst_addr_invalid", 8'(bus_a.addr_invalid), 8'h0);
        bus_a.empty = 3'b111;
        bus_a.full  = 3'b000;
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        tick();

        // Latch address 2 and steer the write.
        bus_a.detect_add = 1'b1;
        bus_a.data_in    = 2'b10;
        tick();
        bus_a.detect_add    = 1'b0;
        bus_a.write_enb_reg = 1'b1;
        #1;
        chk("steer_ch2", 8'(bus_a.write_enb), 8'h4);
        bus_a.full = 3'b100;
        #1;
        chk("fifo_full_hi", 8'(bus_a.fifo_full), 8'h1);
        bus_a.full = 3'b011;
        #1;
        chk("fifo_full_lo", 8'(bus_a.fifo_full), 8'h0);

        // Header and write together: write goes to the old channel.
        bus_a.detect_add = 1'b1;
        bus_a.data_in    = 2'b01;
        #1;
        chk("same_cycle_old", 8'(bus_a.write_enb), 8'h4);
        tick();
        bus_a.detect_add = 1'b0;
        #1;
        chk("same_cycle_new", 8'(bus_a.write_enb), 8'h2);
        chk("fifo_full_ch1", 8'(bus_a.fifo_full), 8'h1);
        bus_a.write_enb_reg = 1'b0;
        bus_a.full          = 3'b000;

        // Channel 1 stalls: pulses at edges 30 and 60.
        bus_a.empty = 3'b101;
        for (int e = 1; e <= 29; e++) begin
            tick();
            chk("stall_pre30", 8'(bus_a.soft_reset), 8'h0);
        end
        tick();
        chk("stall_edge30", 8'(bus_a.soft_reset), 8'h2);
        for (int e = 31; e <= 59; e++) begin
            tick();
            chk("stall_pre60", 8'(bus_a.soft_reset), 8'h0);
        end
        tick();
        chk("stall_edge60", 8'(bus_a.soft_reset), 8'h2);
        bus_a.empty = 3'b111;
        tick();
        chk("stall_drop", 8'(bus_a.soft_reset), 8'h0);

        // Read on the terminal edge suppresses the pulse.
        bus_a.empty = 3'b101;
        for (int e = 1; e <= 29; e++) begin
            tick();
        end
        bus_a.read_enb = 3'b010;
        tick();
        chk("read_wins", 8'(bus_a.soft_reset), 8'h0);
        bus_a.read_enb = 3'b000;
        tick();
        chk("read_wins_next", 8'(bus_a.soft_reset), 8'h0);
        bus_a.empty = 3'b111;
        tick();

        // Out-of-range address blocks writes and masks full.
        bus_a.detect_add = 1'b1;
        bus_a.data_in    = 2'b11;
        tick();
        bus_a.detect_add    = 1'b0;
        bus_a.write_enb_reg = 1'b1;
        bus_a.full          = 3'b111;
        #1;
        chk("inv_flag", 8'(bus_a.addr_invalid), 8'h1);
        chk("inv_write_enb", 8'(bus_a.write_enb), 8'h0);
        chk("inv_fifo_full", 8'(bus_a.fifo_full), 8'h0);
        bus_a.write_enb_reg = 1'b0;
        bus_a.full          = 3'b000;

        // Four-channel instance: address 3 is valid, timeout of 8.
        bus_b.detect_add = 1'b1;
        bus_b.data_in    = 2'b11;
        tick();
        bus_b.detect_add    = 1'b0;
        bus_b.write_enb_reg = 1'b1;
        #1;
        chk("b_steer_ch3", 8'(bus_b.write_enb), 8'h8);
        chk("b_addr_valid", 8'(bus_b.addr_invalid), 8'h0);
        bus_b.write_enb_reg = 1'b0;
        bus_b.empty = 4'b0111;
        #1;
        chk("b_vld_out", 8'(bus_b.vld_out), 8'h8);
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("b_pre8", 8'(bus_b.soft_reset), 8'h0);
        end
        tick();
        chk("b_edge8", 8'(bus_b.soft_reset), 8'h8);
        tick();
        chk("b_edge9", 8'(bus_b.soft_reset), 8'h0);
        bus_b.empty = 4'b1111;

        // Reset mid-count on channel 0 restarts the full window.
        bus_a.empty = 3'b110;
        for (int e = 1; e <= 14; e++) begin
            tick();
        end
        resetn_a = 1'b0;
        #1;
        chk("mid_rst_addr", 8'(bus_a.addr_invalid), 8'h0);
        tick();
        chk("mid_rst_held", 8'(bus_a.soft_reset), 8'h0);
        resetn_a = 1'b1;
        for (int e = 1; e <= 29; e++) begin
            tick();
            chk("mid_rst_pre30", 8'(bus_a.soft_reset), 8'h0);
        end
        tick();
        chk("mid_rst_edge30", 8'(bus_a.soft_reset), 8'h1);
        tick();
        chk("mid_rst_edge31", 8'(bus_a.soft_reset), 8'h0);
        bus_a.empty = 3'b111;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
